// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: command port in, ordered response strobe out.
// Address phase (_p0) and data phase (_p1) overlap so back-to-back commands pipeline.
module ahb_lite_master #(
    parameter int ADDR_SPACE    = 10,
    parameter int DATABUS_WIDTH = 32,
    parameter int HTRANS_WIDTH  = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_SPACE-1:0]    cmd_addr,
    input  logic [DATABUS_WIDTH-1:0] cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATABUS_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_SPACE-1:0]    HADDR,
    output logic [DATABUS_WIDTH-1:0] HWDATA,
    output logic [HTRANS_WIDTH-1:0]  HTRANS,
    output logic                     HWRITE,
    output logic                     HSEL,
    input  logic [DATABUS_WIDTH-1:0] HRDATA,
    input  logic                     HRESP,
    input  logic                     HREADY
);
    localparam logic [HTRANS_WIDTH-1:0] TR_IDLE   = '0;
    localparam logic [HTRANS_WIDTH-1:0] TR_NONSEQ = HTRANS_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        ADDR = 2'b10,
        BOTH = 2'b11
    } state_t;

    state_t                   state;
    logic                     vld_p0;
    logic                     vld_p1;
    logic [DATABUS_WIDTH-1:0] wdata_p0;
    logic                     write_p1;
    logic                     cancel_pend;
    logic                     cancel_rsp_p2;
    logic                     hs;
    logic                     ap_done;
    logic                     dp_done;
    logic                     cancel;
    logic                     vld_p0_nxt;
    logic                     vld_p1_nxt;

    assign {vld_p0, vld_p1} = state;
    assign cmd_ready = !vld_p0 || (HREADY && !HRESP);
    assign hs        = cmd_valid && cmd_ready;
    assign ap_done   = vld_p0 && HREADY;
    assign dp_done   = vld_p1 && HREADY;
    // First ERROR cycle: the queued address phase must not be issued.
    assign cancel    = vld_p1 && HRESP && !HREADY && vld_p0;

    always_comb begin
        vld_p0_nxt = vld_p0;
        if (cancel)
            vld_p0_nxt = 1'b0;
        else if (!vld_p0 || ap_done)
            vld_p0_nxt = hs;

        vld_p1_nxt = vld_p1;
        if (ap_done)
            vld_p1_nxt = 1'b1;
        else if (dp_done)
            vld_p1_nxt = 1'b0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state         <= IDLE;
            HTRANS        <= TR_IDLE;
            HSEL          <= 1'b0;
            HWRITE        <= 1'b0;
            HADDR         <= '0;
            HWDATA        <= '0;
            wdata_p0      <= '0;
            write_p1      <= 1'b0;
            cancel_pend   <= 1'b0;
            cancel_rsp_p2 <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state  <= state_t'({vld_p0_nxt, vld_p1_nxt});
            HTRANS <= vld_p0_nxt ? TR_NONSEQ : TR_IDLE;
            HSEL   <= vld_p0_nxt;

            // p0: address phase capture
            if (hs) begin
                HADDR    <= cmd_addr;
                HWRITE   <= cmd_write;
                wdata_p0 <= cmd_wdata;
            end

            // p1: data phase capture
            if (ap_done) begin
                write_p1 <= HWRITE;
                if (HWRITE)
                    HWDATA <= wdata_p0;
            end

            // p2: response strobe
            rsp_valid     <= 1'b0;
            cancel_rsp_p2 <= 1'b0;
            if (cancel)
                cancel_pend <= 1'b1;
            if (dp_done) begin
                rsp_valid     <= 1'b1;
                rsp_err       <= HRESP;
                rsp_rdata     <= write_p1 ? '0 : HRDATA;
                cancel_rsp_p2 <= cancel_pend;
                cancel_pend   <= 1'b0;
            end else if (cancel_rsp_p2) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed scenarios plus randomized slave/command traffic
// compared each cycle against a transaction-queue reference model.
module tb_ahb_lite_master;
    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        HREADY;

    ahb_lite_master #(
        .ADDR_SPACE(10),
        .DATABUS_WIDTH(32),
        .HTRANS_WIDTH(2)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSEL(HSEL),
        .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: transfers in flight, oldest first, plus scheduled responses.
    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
    } cmd_t;
    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] rd;
    } rsp_t;

    cmd_t        fly[$];
    rsp_t        exp_q[$];
    bit          head_dp;
    bit          owe_cancel;
    logic [9:0]  m_haddr;
    logic        m_hwrite;
    logic [31:0] m_hwdata;
    int unsigned cyc = 0;

    logic        obs_ready, obs_hsel, obs_hwrite, obs_rv, obs_err;
    logic [1:0]  obs_htrans;
    logic [9:0]  obs_haddr;
    logic [31:0] obs_hwdata, obs_rd;

    function automatic bit m_ap();
        return (fly.size() == 2) || (fly.size() == 1 && !head_dp);
    endfunction

    function automatic bit m_dp();
        return (fly.size() >= 1) && head_dp;
    endfunction

    task automatic rst_model();
        fly.delete();
        exp_q.delete();
        head_dp    = 0;
        owe_cancel = 0;
        m_haddr    = '0;
        m_hwrite   = 1'b0;
        m_hwdata   = '0;
    endtask

    task automatic check_cycle();
        bit   ap;
        bit   exp_v;
        rsp_t r;
        @(negedge HCLK);
        ap = m_ap();
        obs_ready = cmd_ready; obs_htrans = HTRANS; obs_hsel = HSEL; obs_haddr = HADDR;
        obs_hwrite = HWRITE; obs_hwdata = HWDATA; obs_rv = rsp_valid; obs_err = rsp_err;
        obs_rd = rsp_rdata;
        chk("cmd_ready", cmd_ready, (!ap || (HREADY && !HRESP)));
        chk("htrans", HTRANS, ap ? 2 : 0);
        chk("hsel", HSEL, ap);
        chk("haddr", HADDR, m_haddr);
        chk("hwrite", HWRITE, m_hwrite);
        chk("hwdata", HWDATA, m_hwdata);
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            r = exp_q.pop_front();
            chk("rsp_err", rsp_err, r.err);
            chk("rsp_rdata", rsp_rdata, r.rd);
        end
    endtask

    task automatic model_step();
        bit   ap, dp, acc;
        rsp_t r;
        cmd_t c;
        ap  = m_ap();
        dp  = m_dp();
        acc = cmd_valid && (!ap || (HREADY && !HRESP));
        if (dp && HREADY) begin
            r.due = cyc + 1;
            r.err = HRESP;
            r.rd  = fly[0].w ? 32'h0 : HRDATA;
            exp_q.push_back(r);
            void'(fly.pop_front());
            head_dp = 0;
            if (owe_cancel) begin
                r.due = cyc + 2;
                r.err = 1'b1;
                r.rd  = 32'h0;
                exp_q.push_back(r);
                owe_cancel = 0;
            end
        end
        if (dp && HRESP && !HREADY && ap) begin
            void'(fly.pop_back());
            owe_cancel = 1;
        end
        if (ap && HREADY) begin
            head_dp = 1;
            if (fly[fly.size()-1].w)
                m_hwdata = fly[fly.size()-1].d;
        end
        if (acc) begin
            c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
            fly.push_back(c);
            m_haddr  = cmd_addr;
            m_hwrite = cmd_write;
        end
        cyc++;
    endtask

    task automatic run(input bit v, input bit w, input logic [9:0] a, input logic [31:0] d,
                       input bit rdy, input bit rsp, input logic [31:0] rd);
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        HREADY = rdy; HRESP = rsp; HRDATA = rd;
        check_cycle();
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        cmd_valid = 1'b0;
        #2;
        chk("rst_htrans", HTRANS, 0);
        chk("rst_hsel", HSEL, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst_model();
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit err2;
        bit rdy, rsp;
        int r;
        HRESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        rst_model();
        #3;
        @(posedge HCLK); #1;
        do_reset();

        // Write then read back-to-back, zero wait.
        run(1, 1, 10'h004, 32'hDEADBEEF, 1, 0, 0); chk("t1_ready", obs_ready, 1);
        run(1, 0, 10'h004, 0, 1, 0, 0);            chk("t1_nonseq_a", obs_htrans, 2);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t1_nonseq_b", obs_htrans, 2);
        chk("t1_hwdata", obs_hwdata, 32'hDEADBEEF);
        run(0, 0, 0, 0, 1, 0, 32'hDEADBEEF);       chk("t1_rsp_a", obs_rv, 1);
        chk("t1_err_a", obs_err, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t1_rsp_b", obs_rv, 1);
        chk("t1_rdata", obs_rd, 32'hDEADBEEF);     chk("t1_err_b", obs_err, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t1_quiet", obs_rv, 0);

        // Single-cycle ERROR on a write, queued read proceeds.
        run(1, 1, 10'h002, 32'h11112222, 1, 0, 0);
        run(1, 0, 10'h010, 0, 1, 0, 0);
        run(0, 0, 0, 0, 1, 1, 0);                  chk("t2_haddr", obs_haddr, 10'h010);
        chk("t2_busy", obs_ready, 0);
        run(0, 0, 0, 0, 1, 0, 32'hA5A5A5A5);       chk("t2_rsp_a", obs_rv, 1);
        chk("t2_err_a", obs_err, 1);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t2_rsp_b", obs_rv, 1);
        chk("t2_err_b", obs_err, 0);               chk("t2_rdata", obs_rd, 32'hA5A5A5A5);

        // Read with three wait states; a write is queued during the wait.
        run(1, 0, 10'h008, 0, 1, 0, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t3_htrans_ap", obs_htrans, 2);
        chk("t3_haddr_ap", obs_haddr, 10'h008);
        run(1, 1, 10'h030, 32'hCAFE0001, 0, 0, 0); chk("t3_w1_htrans", obs_htrans, 0);
        chk("t3_w1_hsel", obs_hsel, 0);            chk("t3_w1_haddr", obs_haddr, 10'h008);
        chk("t3_w1_hwrite", obs_hwrite, 0);        chk("t3_w1_ready", obs_ready, 1);
        run(1, 1, 10'h031, 32'h0, 0, 0, 0);        chk("t3_w2_ready", obs_ready, 0);
        chk("t3_w2_haddr", obs_haddr, 10'h030);    chk("t3_w2_htrans", obs_htrans, 2);
        run(1, 1, 10'h031, 32'h0, 0, 0, 0);        chk("t3_w3_ready", obs_ready, 0);
        chk("t3_w3_haddr", obs_haddr, 10'h030);    chk("t3_w3_rsp", obs_rv, 0);
        run(0, 0, 0, 0, 1, 0, 32'h12345678);       chk("t3_pre_rsp", obs_rv, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t3_rsp", obs_rv, 1);
        chk("t3_rdata", obs_rd, 32'h12345678);     chk("t3_err", obs_err, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t3_wr_rsp", obs_rv, 1);
        chk("t3_wr_rdata", obs_rd, 0);

        // Two-cycle ERROR on a write with a read waiting in the address phase.
        run(1, 1, 10'h001, 32'h55AA55AA, 1, 0, 0);
        run(1, 0, 10'h020, 0, 1, 0, 0);
        run(0, 0, 0, 0, 0, 1, 0);                  chk("t4_ap_nonseq", obs_htrans, 2);
        chk("t4_busy", obs_ready, 0);
        run(0, 0, 0, 0, 1, 1, 0);                  chk("t4_idle", obs_htrans, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t4_rsp_a", obs_rv, 1);
        chk("t4_err_a", obs_err, 1);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t4_rsp_b", obs_rv, 1);
        chk("t4_err_b", obs_err, 1);               chk("t4_rdata_b", obs_rd, 0);
        run(0, 0, 0, 0, 1, 0, 0);                  chk("t4_quiet", obs_rv, 0);

        // Randomized traffic against an AHB-legal random slave.
        err2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (err2) begin
                rdy = 1; rsp = 1; err2 = 0;
            end else if (m_dp()) begin
                r = $urandom_range(0, 9);
                if (r < 6)       begin rdy = 1; rsp = 0; end
                else if (r < 8)  begin rdy = 0; rsp = 0; end
                else if (r == 8) begin rdy = 1; rsp = 1; end
                else             begin rdy = 0; rsp = 1; err2 = 1; end
            end else begin
                rdy = ($urandom_range(0, 3) != 0); rsp = 0;
            end
            run(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 10'($urandom),
                $urandom, rdy, rsp, $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            rsp  = err2;
            err2 = 0;
            run(0, 0, 0, 0, 1, rsp, $urandom);
        end
        chk("drain_empty", exp_q.size() + fly.size(), 0);

        // Reset during a data-phase wait state discards the read.
        run(1, 0, 10'h008, 0, 1, 0, 0);
        run(0, 0, 0, 0, 1, 0, 0);
        run(0, 0, 0, 0, 0, 0, 0);
        HREADY = 1'b0;
        do_reset();
        run(0, 0, 0, 0, 1, 0, 32'h12345678);       chk("t5_ready", obs_ready, 1);
        chk("t5_no_rsp", obs_rv, 0);
        for (int i = 0; i < 4; i++)
            run(0, 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
